// File: rtl/dmem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter_if
//   Bundles the three buses that meet at the data-memory port arbiter:
//     cpu_*  : MEM-stage request (req/we/addr/byte_mark/wdata) and the
//              returned load data / stall.
//     ext_*  : secondary master (debug/DMA) valid/ready request, payload,
//              and the read-return pair (ext_rvalid/ext_rdata).
//     DMEM_* : the single data-memory port.
//   modport slave  : the arbiter's view.
//   modport master : the environment's view (pipeline, external master and
//                    memory together).
// ---------------------------------------------------------------------------
interface dmem_port_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [3:0]  cpu_byte_mark;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;

    logic        ext_valid;
    logic        ext_ready;
    logic        ext_we;
    logic [31:0] ext_addr;
    logic [3:0]  ext_byte_mark;
    logic [31:0] ext_wdata;
    logic        ext_rvalid;
    logic [31:0] ext_rdata;

    logic [31:0] DMEM_add_o;
    logic [3:0]  DMEM_byte_mark_o;
    logic        DMEM_rd_o;
    logic [31:0] DMEM_data_write_o;
    logic [31:0] DMEM_data_i;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_byte_mark, cpu_wdata,
        output cpu_rdata, cpu_stall,
        input  ext_valid, ext_we, ext_addr, ext_byte_mark, ext_wdata,
        output ext_ready, ext_rvalid, ext_rdata,
        output DMEM_add_o, DMEM_byte_mark_o, DMEM_rd_o, DMEM_data_write_o,
        input  DMEM_data_i
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_byte_mark, cpu_wdata,
        input  cpu_rdata, cpu_stall,
        output ext_valid, ext_we, ext_addr, ext_byte_mark, ext_wdata,
        input  ext_ready, ext_rvalid, ext_rdata,
        input  DMEM_add_o, DMEM_byte_mark_o, DMEM_rd_o, DMEM_data_write_o,
        output DMEM_data_i
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//   Shares one data-memory port between the pipeline MEM stage (fixed
//   priority) and an external valid/ready master. Grant is combinational;
//   read data (one-cycle latency) is steered back to whichever side issued
//   the load in the previous cycle.
//
//   Optional feature macro: DMEM_ARB_STARVE_GUARD_EN
//     defined   : a starvation counter forces one external slot (stalling
//                 the pipeline) after STARVE_LIMIT blocked cycles.
//     undefined : pure fixed CPU priority, cpu_stall tied 0.
//
//   Ports:
//     clk   : core clock, rising edge
//     rst_n : synchronous active-low reset
//     bus   : dmem_port_arbiter_if.slave (cpu_*, ext_*, DMEM_* signals)
//
//   Parameter:
//     STARVE_LIMIT : blocked cycles before a forced external slot (1..255)
//
//   State table (guard enabled):
//     ARB_CPU   | normal: CPU first, external when CPU idle
//     ARB_FORCE | one forced external slot, pipeline stalled
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    dmem_port_arbiter_if.slave     bus
);

    typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_EXT} owner_t;

    localparam logic [7:0] LIMIT8 = 8'(STARVE_LIMIT);

    owner_t      r_rd_owner;
    logic [31:0] r_cpu_rdata_hold;
    logic [31:0] r_ext_rdata;

    logic        w_force;
    logic        w_cpu_grant;
    logic        w_ext_grant;
    owner_t      w_rd_owner_live;
    owner_t      w_rd_owner_next;
    logic        w_unused_bits;

`ifdef DMEM_ARB_STARVE_GUARD_EN
    typedef enum logic {ARB_CPU, ARB_FORCE} arb_state_t;

    arb_state_t  r_state;
    logic [7:0]  r_wait_cnt;
    logic [7:0]  w_cnt_inc;

    assign w_force   = (r_state == ARB_FORCE);
    assign w_cnt_inc = (r_wait_cnt >= LIMIT8) ? LIMIT8 : (r_wait_cnt + 8'd1);

    // The transition fires on the cycle whose increment reaches the limit,
    // so the forced slot is the (STARVE_LIMIT+1)-th cycle of waiting.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= ARB_CPU;
            r_wait_cnt <= 8'd0;
        end else begin
            case (r_state)
                ARB_CPU: begin
                    if (bus.ext_valid && !w_ext_grant) begin
                        if (w_cnt_inc == LIMIT8) begin
                            r_state    <= ARB_FORCE;
                            r_wait_cnt <= 8'd0;
                        end else begin
                            r_wait_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_wait_cnt <= 8'd0;
                    end
                end
                default: begin
                    r_state    <= ARB_CPU;
                    r_wait_cnt <= 8'd0;
                end
            endcase
        end
    end
`else
    assign w_force = 1'b0;
`endif

    // Grants collapse to zero while in reset so the port is quiet.
    assign w_cpu_grant = rst_n & ~w_force & bus.cpu_req;
    assign w_ext_grant = rst_n & bus.ext_valid & (w_force | ~bus.cpu_req);

    assign bus.ext_ready = w_ext_grant;
    assign bus.cpu_stall = rst_n & w_force;

    always_comb begin
        bus.DMEM_add_o        = 32'd0;
        bus.DMEM_byte_mark_o  = 4'd0;
        bus.DMEM_rd_o         = 1'b0;
        bus.DMEM_data_write_o = 32'd0;
        if (w_cpu_grant) begin
            bus.DMEM_add_o        = {bus.cpu_addr[31:2], 2'b00};
            bus.DMEM_byte_mark_o  = bus.cpu_we ? bus.cpu_byte_mark : 4'd0;
            bus.DMEM_rd_o         = ~bus.cpu_we;
            bus.DMEM_data_write_o = bus.cpu_wdata;
        end else if (w_ext_grant) begin
            bus.DMEM_add_o        = {bus.ext_addr[31:2], 2'b00};
            bus.DMEM_byte_mark_o  = bus.ext_we ? bus.ext_byte_mark : 4'd0;
            bus.DMEM_rd_o         = ~bus.ext_we;
            bus.DMEM_data_write_o = bus.ext_wdata;
        end
    end

    always_comb begin
        w_rd_owner_next = OWN_NONE;
        if (w_cpu_grant && !bus.cpu_we)
            w_rd_owner_next = OWN_CPU;
        else if (w_ext_grant && !bus.ext_we)
            w_rd_owner_next = OWN_EXT;
    end

    // A read in flight across a reset edge is dropped, not returned.
    assign w_rd_owner_live = rst_n ? r_rd_owner : OWN_NONE;

    assign bus.cpu_rdata  = (w_rd_owner_live == OWN_CPU) ? bus.DMEM_data_i : r_cpu_rdata_hold;
    assign bus.ext_rvalid = (w_rd_owner_live == OWN_EXT);
    assign bus.ext_rdata  = (w_rd_owner_live == OWN_EXT) ? bus.DMEM_data_i : r_ext_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rd_owner       <= OWN_NONE;
            r_cpu_rdata_hold <= 32'd0;
            r_ext_rdata      <= 32'd0;
        end else begin
            r_rd_owner <= w_rd_owner_next;
            if (r_rd_owner == OWN_CPU)
                r_cpu_rdata_hold <= bus.DMEM_data_i;
            if (r_rd_owner == OWN_EXT)
                r_ext_rdata <= bus.DMEM_data_i;
        end
    end

    // Address LSBs are dropped by word alignment; the limit is only used
    // when the guard is built in.
    assign w_unused_bits = ^{bus.cpu_addr[1:0], bus.ext_addr[1:0], LIMIT8};

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    logic [31:0] mem [0:255];
    logic [31:0] dmem_q;

    dmem_port_arbiter_if bus ();

    dmem_port_arbiter #(.STARVE_LIMIT(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural memory: byte-enabled write, one-cycle registered read.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'd0;
            dmem_q <= 32'd0;
        end else begin
            if (bus.DMEM_rd_o) dmem_q <= mem[bus.DMEM_add_o[9:2]];
            for (int b = 0; b < 4; b++)
                if (bus.DMEM_byte_mark_o[b])
                    mem[bus.DMEM_add_o[9:2]][8*b +: 8] <= bus.DMEM_data_write_o[8*b +: 8];
        end
    end
    assign bus.DMEM_data_i = dmem_q;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [3:0] bm, input logic [31:0] data);
        bus.cpu_req = req; bus.cpu_we = we; bus.cpu_addr = addr;
        bus.cpu_byte_mark = bm; bus.cpu_wdata = data;
    endtask

    task automatic set_ext(input logic vld, input logic we, input logic [31:0] addr,
                           input logic [3:0] bm, input logic [31:0] data);
        bus.ext_valid = vld; bus.ext_we = we; bus.ext_addr = addr;
        bus.ext_byte_mark = bm; bus.ext_wdata = data;
    endtask

    task automatic set_idle();
        set_cpu(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_ext(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_cpu(1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        set_ext(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        cyc(); #2;
        n_cmp++; if (bus.DMEM_rd_o !== 1'b0) begin n_err++; $display("FAIL rst_rd got=%b exp=0", bus.DMEM_rd_o); end
        n_cmp++; if (bus.DMEM_byte_mark_o !== 4'h0) begin n_err++; $display("FAIL rst_bm got=%h exp=0", bus.DMEM_byte_mark_o); end
        n_cmp++; if (bus.ext_ready !== 1'b0) begin n_err++; $display("FAIL rst_ext_ready got=%b exp=0", bus.ext_ready); end
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got=%b exp=0", bus.cpu_stall); end
        cyc();
        rst_n = 1'b1;
        set_idle();
        #2;
        n_cmp++; if (bus.ext_rvalid !== 1'b0) begin n_err++; $display("FAIL rst_rvalid got=%b exp=0", bus.ext_rvalid); end
        n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL rst_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
        n_cmp++; if (bus.ext_rdata !== 32'h0) begin n_err++; $display("FAIL rst_ext_rdata got=%h exp=0", bus.ext_rdata); end
        n_cmp++; if (bus.DMEM_add_o !== 32'h0) begin n_err++; $display("FAIL rst_idle_addr got=%h exp=0", bus.DMEM_add_o); end
    endtask

    task automatic test_cpu_store_load();
        cyc(); set_cpu(1'b1, 1'b1, 32'h103, 4'h8, 32'hAB000000); #2;
        n_cmp++; if (bus.DMEM_add_o !== 32'h100) begin n_err++; $display("FAIL st_addr got=%h exp=100", bus.DMEM_add_o); end
        n_cmp++; if (bus.DMEM_byte_mark_o !== 4'h8) begin n_err++; $display("FAIL st_bm got=%h exp=8", bus.DMEM_byte_mark_o); end
        n_cmp++; if (bus.DMEM_rd_o !== 1'b0) begin n_err++; $display("FAIL st_rd got=%b exp=0", bus.DMEM_rd_o); end
        n_cmp++; if (bus.DMEM_data_write_o !== 32'hAB000000) begin n_err++; $display("FAIL st_wdata got=%h exp=ab000000", bus.DMEM_data_write_o); end
        cyc(); set_cpu(1'b1, 1'b0, 32'h100, 4'hF, 32'h0); #2;
        n_cmp++; if (bus.DMEM_rd_o !== 1'b1) begin n_err++; $display("FAIL ld_rd got=%b exp=1", bus.DMEM_rd_o); end
        n_cmp++; if (bus.DMEM_byte_mark_o !== 4'h0) begin n_err++; $display("FAIL ld_bm got=%h exp=0", bus.DMEM_byte_mark_o); end
        cyc(); set_idle(); #2;
        n_cmp++; if (bus.cpu_rdata !== 32'hAB000000) begin n_err++; $display("FAIL ld_cpu_rdata got=%h exp=ab000000", bus.cpu_rdata); end
        n_cmp++; if (bus.DMEM_rd_o !== 1'b0) begin n_err++; $display("FAIL idle_rd got=%b exp=0", bus.DMEM_rd_o); end
    endtask

    task automatic test_ext_store();
        cyc(); set_ext(1'b1, 1'b1, 32'h41, 4'hF, 32'h12345678); #2;
        n_cmp++; if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL exst_ready got=%b exp=1", bus.ext_ready); end
        n_cmp++; if (bus.DMEM_add_o !== 32'h40) begin n_err++; $display("FAIL exst_addr got=%h exp=40", bus.DMEM_add_o); end
        n_cmp++; if (bus.DMEM_byte_mark_o !== 4'hF) begin n_err++; $display("FAIL exst_bm got=%h exp=f", bus.DMEM_byte_mark_o); end
        cyc(); set_ext(1'b1, 1'b1, 32'h44, 4'hF, 32'h5A5AC3C3); #2;
        n_cmp++; if (bus.DMEM_data_write_o !== 32'h5A5AC3C3) begin n_err++; $display("FAIL exst_wdata got=%h exp=5a5ac3c3", bus.DMEM_data_write_o); end
        cyc(); set_idle(); #2;
        n_cmp++; if (bus.ext_rvalid !== 1'b0) begin n_err++; $display("FAIL exst_no_rvalid got=%b exp=0", bus.ext_rvalid); end
    endtask

    task automatic test_ext_load();
        cyc(); set_ext(1'b1, 1'b0, 32'h40, 4'hF, 32'h0); #2;
        n_cmp++; if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL exld_ready got=%b exp=1", bus.ext_ready); end
        n_cmp++; if (bus.DMEM_rd_o !== 1'b1) begin n_err++; $display("FAIL exld_rd got=%b exp=1", bus.DMEM_rd_o); end
        n_cmp++; if (bus.DMEM_byte_mark_o !== 4'h0) begin n_err++; $display("FAIL exld_bm got=%h exp=0", bus.DMEM_byte_mark_o); end
        cyc(); set_idle(); #2;
        n_cmp++; if (bus.ext_rvalid !== 1'b1) begin n_err++; $display("FAIL exld_rvalid got=%b exp=1", bus.ext_rvalid); end
        n_cmp++; if (bus.ext_rdata !== 32'h12345678) begin n_err++; $display("FAIL exld_rdata got=%h exp=12345678", bus.ext_rdata); end
        n_cmp++; if (bus.cpu_rdata !== 32'hAB000000) begin n_err++; $display("FAIL exld_cpu_keep got=%h exp=ab000000", bus.cpu_rdata); end
        cyc(); #2;
        n_cmp++; if (bus.ext_rvalid !== 1'b0) begin n_err++; $display("FAIL exld_rvalid_drop got=%b exp=0", bus.ext_rvalid); end
        n_cmp++; if (bus.ext_rdata !== 32'h12345678) begin n_err++; $display("FAIL exld_rdata_hold got=%h exp=12345678", bus.ext_rdata); end
    endtask

    task automatic test_contention();
        cyc(); set_cpu(1'b1, 1'b0, 32'h100, 4'h0, 32'h0); set_ext(1'b1, 1'b0, 32'h40, 4'h0, 32'h0); #2;
        n_cmp++; if (bus.ext_ready !== 1'b0) begin n_err++; $display("FAIL cont_ready got=%b exp=0", bus.ext_ready); end
        n_cmp++; if (bus.DMEM_add_o !== 32'h100) begin n_err++; $display("FAIL cont_addr got=%h exp=100", bus.DMEM_add_o); end
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL cont_stall got=%b exp=0", bus.cpu_stall); end
        cyc(); set_idle(); #2;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        n_cmp++; if (dut.r_wait_cnt !== 8'd1) begin n_err++; $display("FAIL cont_wait_cnt got=%0d exp=1", dut.r_wait_cnt); end
`endif
        n_cmp++; if (bus.cpu_rdata !== 32'hAB000000) begin n_err++; $display("FAIL cont_cpu_rdata got=%h exp=ab000000", bus.cpu_rdata); end
    endtask

    task automatic test_starvation();
        cyc(); set_idle(); #2;
`ifdef DMEM_ARB_STARVE_GUARD_EN
        for (int i = 1; i <= 8; i++) begin
            cyc();
            set_cpu(1'b1, 1'b0, (i == 8) ? 32'h44 : 32'h100, 4'h0, 32'h0);
            set_ext(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
            #2;
            n_cmp++; if (bus.ext_ready !== 1'b0 || bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL starve_wait[%0d] got ready=%b stall=%b exp 0/0", i, bus.ext_ready, bus.cpu_stall); end
        end
        cyc(); #2;
        n_cmp++; if (bus.cpu_stall !== 1'b1) begin n_err++; $display("FAIL force_stall got=%b exp=1", bus.cpu_stall); end
        n_cmp++; if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL force_ready got=%b exp=1", bus.ext_ready); end
        n_cmp++; if (bus.DMEM_add_o !== 32'h40) begin n_err++; $display("FAIL force_addr got=%h exp=40", bus.DMEM_add_o); end
        n_cmp++; if (bus.cpu_rdata !== 32'h5A5AC3C3) begin n_err++; $display("FAIL force_cpu_rdata got=%h exp=5a5ac3c3", bus.cpu_rdata); end
        cyc(); set_ext(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #2;
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL after_stall got=%b exp=0", bus.cpu_stall); end
        n_cmp++; if (bus.DMEM_add_o !== 32'h44) begin n_err++; $display("FAIL after_addr got=%h exp=44", bus.DMEM_add_o); end
        n_cmp++; if (bus.ext_rvalid !== 1'b1) begin n_err++; $display("FAIL after_rvalid got=%b exp=1", bus.ext_rvalid); end
        n_cmp++; if (bus.ext_rdata !== 32'h12345678) begin n_err++; $display("FAIL after_ext_rdata got=%h exp=12345678", bus.ext_rdata); end
        n_cmp++; if (bus.cpu_rdata !== 32'h5A5AC3C3) begin n_err++; $display("FAIL after_cpu_hold got=%h exp=5a5ac3c3", bus.cpu_rdata); end
        cyc(); set_idle(); #2;
        n_cmp++; if (bus.cpu_rdata !== 32'h5A5AC3C3) begin n_err++; $display("FAIL after_cpu_rdata got=%h exp=5a5ac3c3", bus.cpu_rdata); end
`else
        for (int i = 1; i <= 12; i++) begin
            cyc();
            set_cpu(1'b1, 1'b0, 32'h100, 4'h0, 32'h0);
            set_ext(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
            #2;
            n_cmp++; if (bus.ext_ready !== 1'b0 || bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL prio_wait[%0d] got ready=%b stall=%b exp 0/0", i, bus.ext_ready, bus.cpu_stall); end
        end
        cyc(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #2;
        n_cmp++; if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL prio_release got=%b exp=1", bus.ext_ready); end
        n_cmp++; if (bus.cpu_rdata !== 32'hAB000000) begin n_err++; $display("FAIL prio_cpu_rdata got=%h exp=ab000000", bus.cpu_rdata); end
        cyc(); set_idle(); #2;
        n_cmp++; if (bus.ext_rvalid !== 1'b1) begin n_err++; $display("FAIL prio_rvalid got=%b exp=1", bus.ext_rvalid); end
        n_cmp++; if (bus.ext_rdata !== 32'h12345678) begin n_err++; $display("FAIL prio_ext_rdata got=%h exp=12345678", bus.ext_rdata); end
`endif
    endtask

    task automatic test_back_to_back();
        cyc(); set_cpu(1'b1, 1'b1, 32'h80, 4'hF, 32'hCAFEF00D); #2;
        n_cmp++; if (bus.DMEM_byte_mark_o !== 4'hF) begin n_err++; $display("FAIL b2b_st_bm got=%h exp=f", bus.DMEM_byte_mark_o); end
        cyc(); set_cpu(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); set_ext(1'b1, 1'b0, 32'h82, 4'h0, 32'h0); #2;
        n_cmp++; if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready got=%b exp=1", bus.ext_ready); end
        n_cmp++; if (bus.DMEM_add_o !== 32'h80) begin n_err++; $display("FAIL b2b_ext_addr got=%h exp=80", bus.DMEM_add_o); end
        cyc(); set_cpu(1'b1, 1'b0, 32'h80, 4'h0, 32'h0); set_ext(1'b0, 1'b0, 32'h0, 4'h0, 32'h0); #2;
        n_cmp++; if (bus.ext_rvalid !== 1'b1) begin n_err++; $display("FAIL b2b_rvalid got=%b exp=1", bus.ext_rvalid); end
        n_cmp++; if (bus.ext_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_ext_rdata got=%h exp=cafef00d", bus.ext_rdata); end
        cyc(); set_idle(); #2;
        n_cmp++; if (bus.cpu_rdata !== 32'hCAFEF00D) begin n_err++; $display("FAIL b2b_cpu_rdata got=%h exp=cafef00d", bus.cpu_rdata); end
        n_cmp++; if (bus.ext_rvalid !== 1'b0) begin n_err++; $display("FAIL b2b_rvalid_drop got=%b exp=0", bus.ext_rvalid); end
    endtask

    task automatic test_reset_midop();
        cyc(); set_ext(1'b1, 1'b0, 32'h40, 4'h0, 32'h0); #2;
        n_cmp++; if (bus.ext_ready !== 1'b1) begin n_err++; $display("FAIL mid_ready got=%b exp=1", bus.ext_ready); end
        cyc(); rst_n = 1'b0; set_idle(); #2;
        n_cmp++; if (bus.ext_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rvalid_in_rst got=%b exp=0", bus.ext_rvalid); end
        cyc(); rst_n = 1'b1; #2;
        n_cmp++; if (bus.ext_rvalid !== 1'b0) begin n_err++; $display("FAIL mid_rvalid_after got=%b exp=0", bus.ext_rvalid); end
        n_cmp++; if (bus.cpu_rdata !== 32'h0) begin n_err++; $display("FAIL mid_cpu_rdata got=%h exp=0", bus.cpu_rdata); end
        n_cmp++; if (bus.ext_rdata !== 32'h0) begin n_err++; $display("FAIL mid_ext_rdata got=%h exp=0", bus.ext_rdata); end
        n_cmp++; if (bus.cpu_stall !== 1'b0) begin n_err++; $display("FAIL mid_stall got=%b exp=0", bus.cpu_stall); end
`ifdef DMEM_ARB_STARVE_GUARD_EN
        n_cmp++; if (dut.r_state !== 1'b0) begin n_err++; $display("FAIL mid_state got=%b exp=ARB_CPU", dut.r_state); end
        n_cmp++; if (dut.r_wait_cnt !== 8'd0) begin n_err++; $display("FAIL mid_wait_cnt got=%0d exp=0", dut.r_wait_cnt); end
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        set_idle();
        test_reset();
        test_cpu_store_load();
        test_ext_store();
        test_ext_load();
        test_contention();
        test_starvation();
        test_back_to_back();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
